// File: rtl/pipe_issue.sv
// In-order issue stage: instruction FIFO, operand decode and a WB_LAT-deep busy-register scoreboard.
// One edge from FIFO write to registered issue; hold or hazard keeps the head queued, writes drop when full.

module pipe_issue_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_vld,
  input  logic [W-1:0]           wr_dat,
  output logic                   wr_rdy,
  output logic                   rd_vld,
  output logic [W-1:0]           rd_dat,
  input  logic                   rd_rdy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign pop    = rd_vld && rd_rdy;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign wr_rdy = (count < FULL) || pop;
  assign push   = wr_vld && wr_rdy;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module pipe_issue #(
  parameter int DEPTH  = 4,
  parameter int WB_LAT = 3
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [23:0]            in_instr,
  output logic                   in_ready,
  input  logic                   iss_hold,
  output logic                   iss_valid,
  output logic [3:0]             rs1,
  output logic [3:0]             rs2,
  output logic [3:0]             rd,
  output logic [3:0]             func,
  output logic [7:0]             addr,
  output logic                   stall,
  output logic [7:0]             illegal_cnt,
  output logic [$clog2(DEPTH):0] fifo_count
);
  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] addr;
  } instr_t;

  instr_t            head;
  logic [23:0]       head_dat;
  logic              head_vld;
  logic              illegal;
  logic              uses_rs1;
  logic              uses_rs2;
  logic              hazard;
  logic              issue;
  logic              drop;
  logic [WB_LAT-1:0] sb_vld;
  logic [3:0]        sb_rd [WB_LAT];

  pipe_issue_fifo #(.W(24), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk1),
    .rst_n  (rst_n),
    .wr_vld (in_valid),
    .wr_dat (in_instr),
    .wr_rdy (in_ready),
    .rd_vld (head_vld),
    .rd_dat (head_dat),
    .rd_rdy (issue || drop),
    .count  (fifo_count)
  );

  assign head    = instr_t'(head_dat);
  assign illegal = (head.func > 4'd11);

  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b1;
    case (head.func)
      4'd3, 4'd8, 4'd10, 4'd11: uses_rs2 = 1'b0;
      4'd4, 4'd9:               uses_rs1 = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (sb_vld[i] && ((uses_rs1 && sb_rd[i] == head.rs1) ||
                        (uses_rs2 && sb_rd[i] == head.rs2)))
        hazard = 1'b1;
    end
  end

  // Illegal heads are discarded even under hold so they never block the queue.
  assign issue = head_vld && !illegal && !hazard && !iss_hold;
  assign drop  = head_vld && illegal;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sb_vld <= '0;
      for (int i = 0; i < WB_LAT; i++) sb_rd[i] <= '0;
    end else begin
      sb_vld[0] <= issue;
      sb_rd[0]  <= head.rd;
      for (int i = 1; i < WB_LAT; i++) begin
        sb_vld[i] <= sb_vld[i-1];
        sb_rd[i]  <= sb_rd[i-1];
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid   <= 1'b0;
      stall       <= 1'b0;
      illegal_cnt <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      func        <= '0;
      addr        <= '0;
    end else begin
      iss_valid <= issue;
      stall     <= head_vld && !illegal && hazard;
      if (drop && illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
      if (issue) begin
        rs1  <= head.rs1;
        rs2  <= head.rs2;
        rd   <= head.rd;
        func <= head.func;
        addr <= head.addr;
      end
    end
  end
endmodule

// File: tb/tb_pipe_issue.sv
// Bench for pipe_issue: expected issued words are queued when driven and compared as they issue.
module tb_pipe_issue;
  localparam int DEPTH  = 4;
  localparam int WB_LAT = 3;

  logic        clk1;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in_instr;
  logic        in_ready;
  logic        iss_hold;
  logic        iss_valid;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic        stall;
  logic [7:0]  illegal_cnt;
  logic [2:0]  fifo_count;

  int          checks;
  int          failures;
  logic [23:0] exp_q [$];
  logic [23:0] mon_exp;
  logic [23:0] mon_got;

  pipe_issue #(.DEPTH(DEPTH), .WB_LAT(WB_LAT)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .iss_hold    (iss_hold),
    .iss_valid   (iss_valid),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .func        (func),
    .addr        (addr),
    .stall       (stall),
    .illegal_cnt (illegal_cnt),
    .fifo_count  (fifo_count)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  always @(negedge clk1) begin
    if (iss_valid) begin
      checks++;
      mon_got = {func, rd, rs1, rs2, addr};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue got=%h required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL issue_fields got=%h required=%h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic send(input logic [23:0] w, input bit expect_issue);
    in_valid = 1'b1;
    in_instr = w;
    if (expect_issue) exp_q.push_back(w);
    @(negedge clk1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; iss_hold = 1'b0;
    idle(2);
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL reset_iss_valid got=%b required=0", iss_valid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b required=0", stall); end
    checks++; if (illegal_cnt !== 8'd0) begin failures++; $display("FAIL reset_illegal_cnt got=%0d required=0", illegal_cnt); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_fifo_count got=%0d required=0", fifo_count); end
    checks++; if ({func, rd, rs1, rs2, addr} !== 24'h0) begin failures++; $display("FAIL reset_fields got=%h required=000000", {func, rd, rs1, rs2, addr}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic;
    send(24'h031210, 1'b1);
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL basic_early got=%b required=0", iss_valid); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d required=1", fifo_count); end
    @(negedge clk1);
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b required=1", iss_valid); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL basic_drain got=%0d required=0", fifo_count); end
    idle(WB_LAT + 2);
  endtask

  task automatic test_hazard;
    send(24'h031210, 1'b1);
    send(24'h143220, 1'b1);
    for (int k = 2; k <= 7; k++) begin
      checks++;
      if (iss_valid !== (k == 2 || k == 6)) begin failures++; $display("FAIL hazard_iss_valid c%0d got=%b required=%b", k, iss_valid, (k == 2 || k == 6)); end
      checks++;
      if (stall !== (k >= 3 && k <= 5)) begin failures++; $display("FAIL hazard_stall c%0d got=%b required=%b", k, stall, (k >= 3 && k <= 5)); end
      @(negedge clk1);
    end
    idle(WB_LAT + 2);
  endtask

  task automatic test_operand;
    send(24'h351030, 1'b1);
    send(24'h465131, 1'b1);
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL operand_a got=%b required=1", iss_valid); end
    send(24'h881632, 1'b1);
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL operand_rs2_only got=%b required=1", iss_valid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL operand_stall_b got=%b required=0", stall); end
    @(negedge clk1);
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL operand_rs1_only got=%b required=1", iss_valid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL operand_stall_c got=%b required=0", stall); end
    idle(WB_LAT + 2);
  endtask

  task automatic test_illegal;
    logic [23:0] w;
    send(24'hC00000, 1'b0);
    send(24'hF12345, 1'b0);
    idle(2);
    checks++; if (illegal_cnt !== 8'd2) begin failures++; $display("FAIL illegal_two got=%0d required=2", illegal_cnt); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL illegal_popped got=%0d required=0", fifo_count); end
    for (int i = 0; i < 300; i++) begin
      w = 24'($urandom);
      w[23:20] = 4'(12 + $urandom_range(0, 3));
      send(w, 1'b0);
    end
    idle(2);
    checks++; if (illegal_cnt !== 8'd255) begin failures++; $display("FAIL illegal_saturate got=%0d required=255", illegal_cnt); end
    idle(2);
  endtask

  task automatic test_full_hold;
    iss_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_ready_%0d got=%b required=1", i, in_ready); end
      send({4'h0, 4'(i + 1), 8'h00, 8'(64 + i)}, 1'b1);
    end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b required=0", in_ready); end
    checks++; if (fifo_count !== 3'(DEPTH)) begin failures++; $display("FAIL full_count got=%0d required=%0d", fifo_count, DEPTH); end
    send(24'h0600FF, 1'b0);
    checks++; if (fifo_count !== 3'(DEPTH)) begin failures++; $display("FAIL full_extra_lost got=%0d required=%0d", fifo_count, DEPTH); end
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL hold_no_issue got=%b required=0", iss_valid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL hold_no_stall got=%b required=0", stall); end
    iss_hold = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_pop_ready got=%b required=1", in_ready); end
    @(negedge clk1);
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (iss_valid !== 1'b1) begin failures++; $display("FAIL drain_issue_%0d got=%b required=1", k, iss_valid); end
      @(negedge clk1);
    end
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL drain_done got=%b required=0", iss_valid); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL drain_count got=%0d required=0", fifo_count); end
    idle(WB_LAT + 2);
  endtask

  task automatic test_reset_mid;
    send(24'h090050, 1'b1);
    send(24'h0A9051, 1'b0);
    send(24'h0B0052, 1'b0);
    send(24'h0C0053, 1'b0);
    checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL mid_count got=%0d required=3", fifo_count); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mid_stall got=%b required=1", stall); end
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL arst_iss_valid got=%b required=0", iss_valid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL arst_stall got=%b required=0", stall); end
    checks++; if (illegal_cnt !== 8'd0) begin failures++; $display("FAIL arst_illegal_cnt got=%0d required=0", illegal_cnt); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL arst_fifo_count got=%0d required=0", fifo_count); end
    checks++; if ({func, rd, rs1, rs2, addr} !== 24'h0) begin failures++; $display("FAIL arst_fields got=%h required=000000", {func, rd, rs1, rs2, addr}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready got=%b required=1", in_ready); end
    @(negedge clk1);
    rst_n = 1'b1;
    send(24'h0D9A54, 1'b1);
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL post_rst_early got=%b required=0", iss_valid); end
    @(negedge clk1);
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL post_rst_issue got=%b required=1", iss_valid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL post_rst_stall got=%b required=0", stall); end
    idle(WB_LAT + 2);
  endtask

  task automatic test_end;
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL pending_issues got=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_basic;
    test_hazard;
    test_operand;
    test_illegal;
    test_full_hold;
    test_reset_mid;
    test_end;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
